instruction_sequencer: RTL



---
 rtl/instruction_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Front end of the CPU control unit. Holds the instruction register, runs the
//   T-state ring (T1..T4) and the M-cycle counter (M1..M8), registers the
//   one-hot opcode field decode and produces the branch-condition vector.
//
// Ports
//   i_Clk, i_Rst_n   clock (rising edge), asynchronous active-low reset
//   i_Wait           freezes all sequencer state while high
//   i_Bus_Data[7:0]  opcode source on fetch
//   i_Fetch          load IR and restart at M1 (T4 only)
//   i_Reset_Cycle    restart at M1 without loading IR (T4 only)
//   i_CB_Prefix      opcode being fetched is CB-page (T4 with i_Fetch only)
//   i_Flags[3:0]     {Z,N,H,C}
//   o_Cycle_Step     one-hot T-state, bit0 = T1
//   o_Cycle_Count    one-hot M-cycle, bit0 = M1
//   o_IR             current opcode
//   o_X/o_Y/o_Z/o_P/o_Q  registered one-hot opcode fields
//   o_CB             current opcode is CB-page
//   o_Conditions     {C, ~C, Z, ~Z} (combinational)
//   o_Seq_Error      sticky M-cycle overrun flag
module instruction_sequencer #(
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Wait,
    input  logic [7:0] i_Bus_Data,
    input  logic       i_Fetch,
    input  logic       i_Reset_Cycle,
    input  logic       i_CB_Prefix,
    input  logic [3:0] i_Flags,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic [3:0] o_X,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q,
    output logic       o_CB,
    output logic [3:0] o_Conditions,
    output logic       o_Seq_Error
);

    // T-state encodings double as the one-hot o_Cycle_Step value
    typedef enum logic [3:0] {
        T1 = 4'b0001,
        T2 = 4'b0010,
        T3 = 4'b0100,
        T4 = 4'b1000
    } t_state_e;

    t_state_e   step_q, step_d;
    logic [7:0] count_q, count_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] z_q, z_d;
    logic [3:0] p_q, p_d;
    logic [1:0] q_q, q_d;
    logic       cb_q, cb_d;
    logic       seq_err_q, seq_err_d;

    // N and H do not take part in any branch condition
    logic unused_flags;
    assign unused_flags = ^i_Flags[2:1];

    always_comb begin
        step_d    = step_q;
        count_d   = count_q;
        ir_d      = ir_q;
        cb_d      = cb_q;
        seq_err_d = seq_err_q;

        if (!i_Wait) begin
            case (step_q)
                T1: step_d = T2;
                T2: step_d = T3;
                T3: step_d = T4;
                T4: begin
                    step_d = T1;
                    if (i_Fetch) begin
                        count_d = 8'h01;
                        ir_d    = i_Bus_Data;
                        cb_d    = i_CB_Prefix;
                    end else if (i_Reset_Cycle) begin
                        count_d = 8'h01;
                    end else if (count_q[7]) begin
                        // Ran past M8 without a fetch: wrap and flag it
                        count_d   = 8'h01;
                        seq_err_d = 1'b1;
                    end else begin
                        count_d = count_q << 1;
                    end
                end
                default: step_d = T1;
            endcase
        end

        // Decode follows ir_d so it is reloaded on exactly the IR load edge
        x_d = 4'b0001 << ir_d[7:6];
        y_d = 8'h01 << ir_d[5:3];
        z_d = 8'h01 << ir_d[2:0];
        p_d = 4'b0001 << ir_d[5:4];
        q_d = 2'b01 << ir_d[3];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            step_q    <= T1;
            count_q   <= 8'h01;
            ir_q      <= RESET_OPCODE;
            x_q       <= 4'b0001 << RESET_OPCODE[7:6];
            y_q       <= 8'h01 << RESET_OPCODE[5:3];
            z_q       <= 8'h01 << RESET_OPCODE[2:0];
            p_q       <= 4'b0001 << RESET_OPCODE[5:4];
            q_q       <= 2'b01 << RESET_OPCODE[3];
            cb_q      <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            count_q   <= count_d;
            ir_q      <= ir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            p_q       <= p_d;
            q_q       <= q_d;
            cb_q      <= cb_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_IR          = ir_q;
    assign o_X           = x_q;
    assign o_Y           = y_q;
    assign o_Z           = z_q;
    assign o_P           = p_q;
    assign o_Q           = q_q;
    assign o_CB          = cb_q;
    assign o_Seq_Error   = seq_err_q;
    assign o_Conditions  = {i_Flags[0], ~i_Flags[0], i_Flags[3], ~i_Flags[3]};

endmodule
